decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, immediate/output data width; SHALL be >= 10.
REQ-002 Parameter IMM_SIGNED, default 1; 1 = sign-extend immediate, 0 = zero-extend.
REQ-003 Parameter CNT_W, default 8, width of the illegal-instruction counter.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  upstream instruction valid.
REQ-007 in_ready  out  1  block can accept an instruction this cycle.
REQ-008 in_instr  in  32  instruction word: opcode [31:25], rs1 [24:20], rs2 [19:15], rd [14:10], imm [9:0].
REQ-009 flush  in  1  discard held output; blocks acceptance this cycle.
REQ-010 out_valid  out  1  decoded instruction held and valid.
REQ-011 out_ready  in  1  downstream accepts the held instruction.
REQ-012 out_alu_op  out  3  decoded ALU operation.
REQ-013 out_rs1, out_rs2, out_rd  out  5 each  register addresses.
REQ-014 out_imm  out  XLEN  extended immediate.
REQ-015 out_uses_rs2  out  1  1 for R-type instructions (opcodes 2-5).
REQ-016 out_illegal  out  1  held instruction had an undefined opcode.
REQ-017 illegal_count  out  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-018 Opcodes 0-1: alu_op = opcode[2:0]; rs1/rs2/rd/imm = 0; uses_rs2 = 0.
REQ-019 Opcodes 2-5 (R-type): alu_op = opcode[2:0]; rs1/rs2/rd from fields; imm = 0; uses_rs2 = 1.
REQ-020 Opcodes 6-7 (I-type): alu_op = opcode[2:0]; rs1, rd from fields; rs2 = 0; imm = imm[9:0] extended to XLEN per IMM_SIGNED; uses_rs2 = 0.
REQ-021 Opcodes 8-127: all fields 0, alu_op = 0, illegal = 1; otherwise illegal = 0.
REQ-022 Two states: EMPTY (out_valid = 0) and FULL (out_valid = 1).
REQ-023 in_ready = !flush && (!out_valid || out_ready); in_ready is combinational, and it is 0 while rst = 1.
REQ-024 Accept = in_valid && in_ready; on accept, decoded fields are registered and out_valid = 1 next cycle (latency 1).
REQ-025 FULL with out_ready = 1 and a simultaneous accept: outputs are replaced with the new instruction, out_valid stays 1, and there is no bubble.
REQ-026 FULL with out_ready = 1 and no accept: go to EMPTY next cycle.
REQ-027 FULL with out_ready = 0: all out_* stay stable until the handshake completes.
REQ-028 Flush has priority over the handshake: next cycle out_valid = 0, nothing is accepted, and out_* data fields hold their values.
REQ-029 illegal_count increments by 1 on each accept with an undefined opcode, saturates at all-ones, and is unaffected by flush.

Reset
REQ-030 While rst = 1 at a clock edge: out_valid = 0, all out_* data = 0, illegal_count = 0, and the state is EMPTY.
REQ-031 An instruction presented while rst = 1 is not accepted, including when rst rises mid-transfer, and no output is produced for it.

Verification
REQ-032 Reset, then in_instr = 0x04321400 with in_valid = 1 -> next cycle out_valid = 1, alu_op = 2, rs1 = 3, rs2 = 4, rd = 5, imm = 0, uses_rs2 = 1.
REQ-033 in_instr = 0x0C100BFF -> alu_op = 6, rs1 = 1, rd = 2, rs2 = 0; imm = 0xFFFFFFFF for IMM_SIGNED = 1, 0x000003FF for IMM_SIGNED = 0.
REQ-034 out_ready held 0 for 5 cycles with in_valid = 1 -> in_ready = 0 and out_* stable; then out_ready = 1 -> the next instruction is accepted the same cycle with no bubble.
REQ-035 Back-to-back accepts of 0xFE000000, with out_ready = 1 and CNT_W = 2 -> out_illegal = 1 and fields 0; illegal_count reads 1, 2, 3, 3 after the 1st to 4th accepts (saturates at 3).
REQ-036 flush = 1 while FULL with in_valid = 1 -> in_ready = 0, next cycle out_valid = 0, and illegal_count is unchanged.
REQ-037 rst = 1 while FULL -> next cycle out_valid = 0, all outputs 0, and illegal_count = 0.

Source files
------------

// File: rtl/decode_stage.sv
// Single-entry decode stage: splits a 32-bit instruction into ALU op, register
// addresses and an extended immediate, held in a valid/ready output register.
module decode_stage #(
  parameter int XLEN       = 32,
  parameter bit IMM_SIGNED = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_alu_op,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_uses_rs2,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [6:0]       opcode;
  logic             accept;
  logic [XLEN-1:0]  immExt;
  logic [2:0]       decAluOp;
  logic [4:0]       decRs1;
  logic [4:0]       decRs2;
  logic [4:0]       decRd;
  logic [XLEN-1:0]  decImm;
  logic             decUsesRs2;
  logic             decIllegal;

  assign opcode    = in_instr[31:25];
  assign immExt    = IMM_SIGNED ? {{(XLEN-10){in_instr[9]}}, in_instr[9:0]}
                                : {{(XLEN-10){1'b0}}, in_instr[9:0]};
  assign out_valid = (state == FULL);
  assign in_ready  = !rst && !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  // Fields not used by an opcode class decode to zero so downstream never sees stale bits.
  always_comb begin
    decAluOp   = 3'd0;
    decRs1     = 5'd0;
    decRs2     = 5'd0;
    decRd      = 5'd0;
    decImm     = '0;
    decUsesRs2 = 1'b0;
    decIllegal = 1'b0;
    case (opcode)
      7'd0, 7'd1: begin
        decAluOp = opcode[2:0];
      end
      7'd2, 7'd3, 7'd4, 7'd5: begin
        decAluOp   = opcode[2:0];
        decRs1     = in_instr[24:20];
        decRs2     = in_instr[19:15];
        decRd      = in_instr[14:10];
        decUsesRs2 = 1'b1;
      end
      7'd6, 7'd7: begin
        decAluOp = opcode[2:0];
        decRs1   = in_instr[24:20];
        decRd    = in_instr[14:10];
        decImm   = immExt;
      end
      default: begin
        decIllegal = 1'b1;
      end
    endcase
  end

  // Flush wins over the handshake and leaves the data fields untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EMPTY;
      out_alu_op    <= 3'd0;
      out_rs1       <= 5'd0;
      out_rs2       <= 5'd0;
      out_rd        <= 5'd0;
      out_imm       <= '0;
      out_uses_rs2  <= 1'b0;
      out_illegal   <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (accept) begin
      state        <= FULL;
      out_alu_op   <= decAluOp;
      out_rs1      <= decRs1;
      out_rs2      <= decRs2;
      out_rd       <= decRd;
      out_imm      <= decImm;
      out_uses_rs2 <= decUsesRs2;
      out_illegal  <= decIllegal;
      if (decIllegal && (illegal_count != {CNT_W{1'b1}})) begin
        illegal_count <= illegal_count + CNT_W'(1);
      end
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a driver pushes reference decodes on accept,
// a negedge monitor compares the held output and handshake signals against them.
module tb_decode_stage;

  localparam int XLEN       = 32;
  localparam bit IMM_SIGNED = 1'b1;
  localparam int CNT_W      = 2;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [2:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        uses;
    logic        ill;
  } rec_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_alu_op;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [XLEN-1:0]  out_imm;
  logic             out_uses_rs2;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_count;

  rec_t q[$];
  rec_t held;
  logic holdValid;
  logic expReady;
  int   mcount;
  logic started;
  int   errors;
  int   checks;

  decode_stage #(.XLEN(XLEN), .IMM_SIGNED(IMM_SIGNED), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_alu_op(out_alu_op), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_uses_rs2(out_uses_rs2), .out_illegal(out_illegal),
    .illegal_count(illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written from the opcode-class rules with plain arithmetic.
  function automatic rec_t decodeRef(input logic [31:0] instr);
    rec_t r;
    int op;
    int iv;
    r  = '0;
    op = int'(instr >> 25);
    if (op >= 8) begin
      r.ill = 1'b1;
    end else begin
      r.alu = 3'(op);
      if (op >= 2 && op <= 5) begin
        r.rs1  = 5'((instr >> 20) % 32);
        r.rs2  = 5'((instr >> 15) % 32);
        r.rd   = 5'((instr >> 10) % 32);
        r.uses = 1'b1;
      end else if (op >= 6) begin
        r.rs1 = 5'((instr >> 20) % 32);
        r.rd  = 5'((instr >> 10) % 32);
        iv    = int'(instr % 1024);
        if (IMM_SIGNED && iv >= 512) iv = iv - 1024;
        r.imm = 32'(iv);
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkFields(input string tag, input rec_t e);
    checkOutput({tag, " alu_op"}, 32'(out_alu_op), 32'(e.alu));
    checkOutput({tag, " rs1"}, 32'(out_rs1), 32'(e.rs1));
    checkOutput({tag, " rs2"}, 32'(out_rs2), 32'(e.rs2));
    checkOutput({tag, " rd"}, 32'(out_rd), 32'(e.rd));
    checkOutput({tag, " imm"}, out_imm, e.imm);
    checkOutput({tag, " uses_rs2"}, 32'(out_uses_rs2), 32'(e.uses));
    checkOutput({tag, " illegal"}, 32'(out_illegal), 32'(e.ill));
  endtask

  // Drives one cycle of inputs, then advances the reference state past the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] instr,
                               input logic ordy, input logic fl, input logic r);
    rec_t e;
    in_valid  = v;
    in_instr  = instr;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    expReady  = !r && !fl && (q.size() == 0 || ordy);
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      mcount    = 0;
      held      = '0;
      holdValid = 1'b1;
    end else if (fl) begin
      if (q.size() != 0) begin
        held      = q[0];
        holdValid = 1'b1;
      end
      q.delete();
    end else if (v && expReady) begin
      e = decodeRef(instr);
      q.push_back(e);
      holdValid = 1'b0;
      if (e.ill && mcount < CNT_MAX) mcount++;
    end
  endtask

  // Monitor: every held cycle the outputs must match the front of the scoreboard.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("in_ready", 32'(in_ready), 32'(expReady));
      checkOutput("out_valid", 32'(out_valid), 32'(q.size() != 0));
      checkOutput("illegal_count", 32'(illegal_count), 32'(mcount));
      if (q.size() != 0) begin
        checkFields("held", q[0]);
        if (out_ready && !flush && !rst) begin
          void'(q.pop_front());
          holdValid = 1'b0;
        end
      end else if (holdValid) begin
        checkFields("idle", held);
      end
    end
  end

  initial begin
    logic [31:0] instr;
    int op;
    errors    = 0;
    checks    = 0;
    mcount    = 0;
    started   = 1'b0;
    holdValid = 1'b0;
    held      = '0;
    expReady  = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;

    applyStimulus(1'b1, 32'h04321400, 1'b1, 1'b0, 1'b1);
    started = 1'b1;
    applyStimulus(1'b1, 32'h04321400, 1'b1, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'h04321400, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0C100BFF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h0A0A2C01, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0A0A2C01, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hFE000000, 1'b1, 1'b0, 1'b0);

    applyStimulus(1'b1, 32'h0E5F0A00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hFE000000, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);

    applyStimulus(1'b1, 32'hFE000000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h12000000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h04321400, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 9));
      if (op >= 8) op = int'($urandom_range(8, 127));
      instr = {7'(op), 25'($urandom)};
      applyStimulus($urandom_range(0, 3) != 0, instr, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0);
    end
    applyStimulus(1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
